// File: rtl/ddr3_axi4_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_axi4_pkg
//   Shared definitions for the DDR3 AXI4 read-path blocks:
//     - AXI4 burst-type encodings
//     - default bus widths of the DDR3 AXI slave (axi_translator_s0)
//     - state type of the read splitter FSM
// ---------------------------------------------------------------------------
package ddr3_axi4_pkg;

   // AXI4 ARBURST / AWBURST encodings
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Default widths of the DDR3 AXI slave port
   localparam int unsigned DDR3_ADDR_W = 30;
   localparam int unsigned DDR3_DATA_W = 64;
   localparam int unsigned DDR3_ID_W   = 4;

   // Read splitter FSM
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_split_state_e;

endpackage : ddr3_axi4_pkg

// File: rtl/ddr3_axi4_rd_splitter.sv
// ---------------------------------------------------------------------------
// ddr3_axi4_rd_splitter
//   Read-path shim between the U500 memory-port AXI4 master (s_*) and the
//   DDR3 AXI4 slave (m_*). Long INCR read bursts are cut into sub-bursts of
//   at most MAX_BEATS beats so the controller's command queue is not held by
//   one long burst; the R stream is passed straight back with a single rlast
//   per original burst. One original burst is in flight at a time.
//
// Ports
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   s_ar*  (in) / s_arready (out)   master-side read address channel
//   s_r*   (out) / s_rready (in)    master-side read data channel
//   m_ar*  (out, registered)        slave-side read address channel
//   m_arready (in)
//   m_r*   (in) / m_rready (out)    slave-side read data channel
// ---------------------------------------------------------------------------
module ddr3_axi4_rd_splitter
   import ddr3_axi4_pkg::*;
#(
   parameter int unsigned ADDR_W    = DDR3_ADDR_W,
   parameter int unsigned DATA_W    = DDR3_DATA_W,
   parameter int unsigned ID_W      = DDR3_ID_W,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,

   // master-side AR
   input  logic [ID_W-1:0]   s_arid,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic [7:0]        s_arlen,
   input  logic [2:0]        s_arsize,
   input  logic [1:0]        s_arburst,
   input  logic              s_arlock,
   input  logic [3:0]        s_arcache,
   input  logic [2:0]        s_arprot,
   input  logic [3:0]        s_arqos,
   input  logic              s_arvalid,
   output logic              s_arready,

   // master-side R
   output logic [ID_W-1:0]   s_rid,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic              s_rvalid,
   input  logic              s_rready,

   // slave-side AR
   output logic [ID_W-1:0]   m_arid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   output logic              m_arlock,
   output logic [3:0]        m_arcache,
   output logic [2:0]        m_arprot,
   output logic [3:0]        m_arqos,
   output logic              m_arvalid,
   input  logic              m_arready,

   // slave-side R
   input  logic [ID_W-1:0]   m_rid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rlast,
   input  logic              m_rvalid,
   output logic              m_rready
);

   localparam logic [8:0] MAX_B9 = 9'(MAX_BEATS);

   // AR length of a sub-burst given the beats still to be requested
   function automatic logic [7:0] sub_len(input logic [8:0] beats);
      logic [8:0] n;
      n = (beats > MAX_B9) ? MAX_B9 : beats;
      return 8'(n - 9'd1);
   endfunction

   rd_split_state_e   state_q, state_d;

   logic [ID_W-1:0]   id_q,      id_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [7:0]        len_q,     len_d;
   logic [2:0]        size_q,    size_d;
   logic [1:0]        burst_q,   burst_d;
   logic              lock_q,    lock_d;
   logic [3:0]        cache_q,   cache_d;
   logic [2:0]        prot_q,    prot_d;
   logic [3:0]        qos_q,     qos_d;
   logic              arvalid_q, arvalid_d;

   logic [8:0]        total_q,   total_d;
   logic [8:0]        rem_q,     rem_d;
   logic [8:0]        rcnt_q,    rcnt_d;

   logic              ar_hs;
   logic              r_hs;
   logic              last_beat;
   logic [8:0]        total_new;
   logic [8:0]        rem_after;
   logic [ADDR_W-1:0] size_mask;
   logic [ADDR_W-1:0] step;

   // rlast is regenerated from the beat count, so the slave's own rlast
   // (which also pulses at every sub-burst boundary) is not used.
   logic unused_m_rlast;
   assign unused_m_rlast = m_rlast;

   assign ar_hs     = arvalid_q & m_arready;
   assign r_hs      = m_rvalid & s_rready;
   assign last_beat = (rcnt_q == (total_q - 9'd1));
   assign total_new = {1'b0, s_arlen} + 9'd1;
   assign rem_after = rem_q - ({1'b0, len_q} + 9'd1);
   assign size_mask = (ADDR_W'(1) << size_q) - ADDR_W'(1);
   assign step      = ADDR_W'(MAX_BEATS) << size_q;

   // Gated with reset so that no request is taken while reset is held.
   assign s_arready = (state_q == ST_IDLE) & reset_reset_n;

   // R path: straight pass-through, only rlast is recomputed
   assign s_rvalid = m_rvalid;
   assign m_rready = s_rready;
   assign s_rid    = m_rid;
   assign s_rdata  = m_rdata;
   assign s_rresp  = m_rresp;
   assign s_rlast  = m_rvalid & (state_q != ST_IDLE) & last_beat;

   // AR outputs come straight from registers
   assign m_arid    = id_q;
   assign m_araddr  = addr_q;
   assign m_arlen   = len_q;
   assign m_arsize  = size_q;
   assign m_arburst = burst_q;
   assign m_arlock  = lock_q;
   assign m_arcache = cache_q;
   assign m_arprot  = prot_q;
   assign m_arqos   = qos_q;
   assign m_arvalid = arvalid_q;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      lock_d    = lock_q;
      cache_d   = cache_q;
      prot_d    = prot_q;
      qos_d     = qos_q;
      arvalid_d = arvalid_q;
      total_d   = total_q;
      rem_d     = rem_q;
      rcnt_d    = rcnt_q;

      unique case (state_q)
         ST_IDLE: begin
            // R beats seen here are protocol violations: passed, not counted
            if (s_arvalid && s_arready) begin
               id_d      = s_arid;
               addr_d    = s_araddr;
               size_d    = s_arsize;
               burst_d   = s_arburst;
               lock_d    = s_arlock;
               cache_d   = s_arcache;
               prot_d    = s_arprot;
               qos_d     = s_arqos;
               total_d   = total_new;
               rem_d     = total_new;
               rcnt_d    = '0;
               // only INCR is ever cut; FIXED/WRAP go through whole
               len_d     = (s_arburst == BURST_INCR) ? sub_len(total_new) : s_arlen;
               arvalid_d = 1'b1;
               state_d   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // data of earlier sub-bursts may already be returning
            if (r_hs) begin
               rcnt_d = rcnt_q + 9'd1;
            end
            if (ar_hs) begin
               rem_d = rem_after;
               if (rem_after == '0) begin
                  arvalid_d = 1'b0;
                  state_d   = ST_DRAIN;
               end else begin
                  // next sub-burst starts on a size-aligned address
                  addr_d = (addr_q & ~size_mask) + step;
                  len_d  = sub_len(rem_after);
               end
            end
         end

         ST_DRAIN: begin
            if (r_hs) begin
               rcnt_d = rcnt_q + 9'd1;
               if (last_beat) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         lock_q    <= 1'b0;
         cache_q   <= '0;
         prot_q    <= '0;
         qos_q     <= '0;
         arvalid_q <= 1'b0;
         total_q   <= '0;
         rem_q     <= '0;
         rcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         lock_q    <= lock_d;
         cache_q   <= cache_d;
         prot_q    <= prot_d;
         qos_q     <= qos_d;
         arvalid_q <= arvalid_d;
         total_q   <= total_d;
         rem_q     <= rem_d;
         rcnt_q    <= rcnt_d;
      end
   end

endmodule : ddr3_axi4_rd_splitter

// File: tb/tb_ddr3_axi4_rd_splitter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_axi4_rd_splitter
//   Self-checking bench: a reference model turns each original burst into the
//   list of sub-bursts it must become; a slave model answers every accepted
//   sub-burst with random data and stalls, and a monitor checks AR fields,
//   AR stability, R pass-through and the single final rlast.
// ---------------------------------------------------------------------------
module tb_ddr3_axi4_rd_splitter;
   import ddr3_axi4_pkg::*;

   localparam int unsigned ADDR_W    = 30;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned ID_W      = 4;
   localparam int unsigned MAX_BEATS = 16;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic [ID_W-1:0]   s_arid = '0;
   logic [ADDR_W-1:0] s_araddr = '0;
   logic [7:0]        s_arlen = '0;
   logic [2:0]        s_arsize = '0;
   logic [1:0]        s_arburst = '0;
   logic              s_arlock = 1'b0;
   logic [3:0]        s_arcache = '0;
   logic [2:0]        s_arprot = '0;
   logic [3:0]        s_arqos = '0;
   logic              s_arvalid = 1'b0;
   logic              s_arready;
   logic [ID_W-1:0]   s_rid;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic              s_rvalid;
   logic              s_rready = 1'b1;
   logic [ID_W-1:0]   m_arid;
   logic [ADDR_W-1:0] m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_arlock;
   logic [3:0]        m_arcache;
   logic [2:0]        m_arprot;
   logic [3:0]        m_arqos;
   logic              m_arvalid;
   logic              m_arready = 1'b1;
   logic [ID_W-1:0]   m_rid = '0;
   logic [DATA_W-1:0] m_rdata = '0;
   logic [1:0]        m_rresp = '0;
   logic              m_rlast = 1'b0;
   logic              m_rvalid = 1'b0;
   logic              m_rready;

   always #5 clk_clk = ~clk_clk;

   ddr3_axi4_rd_splitter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
      .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
      .m_arprot(m_arprot), .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
   } ar_exp_t;

   ar_exp_t           exp_ar[$];
   logic [20:0]       exp_attr;
   logic [ID_W-1:0]   cur_id;
   int unsigned       exp_total;
   int unsigned       beat_idx;
   bit                done;
   bit                busy;

   function automatic void model_split(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
      int unsigned total;
      longint unsigned bytes, base, a;
      int unsigned left, n;
      ar_exp_t e;
      total = int'(len) + 1;
      bytes = 64'd1 << size;
      base  = (longint'(addr) / bytes) * bytes;
      if (burst != BURST_INCR || total <= MAX_BEATS) begin
         e.addr = addr;
         e.len  = len;
         exp_ar.push_back(e);
      end else begin
         for (int unsigned k = 0; k * MAX_BEATS < total; k++) begin
            left = total - k * MAX_BEATS;
            n    = (left < MAX_BEATS) ? left : MAX_BEATS;
            a    = (k == 0) ? longint'(addr) : base + longint'(k * MAX_BEATS) * bytes;
            e.addr = ADDR_W'(a);
            e.len  = 8'(n - 1);
            exp_ar.push_back(e);
         end
      end
   endfunction

   // ---------------- slave model + monitor ----------------
   int unsigned pend[$];
   int unsigned cur_left = 0;
   int unsigned ar_stall = 0;
   bit          rand_r = 1'b0;
   bit          rand_ar = 1'b0;
   bit          held_v = 1'b0;
   logic [58:0] held;
   int unsigned b2b_flag = 0;

   always begin : slave_bfm
      bit      r_hs;
      ar_exp_t e;
      @(negedge clk_clk);
      r_hs = 1'b0;
      if (reset_reset_n) begin
         if (b2b_flag == 1) chk("ar_b2b", m_arvalid, 1'b1);
         else if (b2b_flag == 2) chk("ar_drop", m_arvalid, 1'b0);
         b2b_flag = 0;
         if (busy) chk("s_arready_busy", s_arready, 1'b0);
         if (m_arvalid) begin
            if (held_v)
               chk("ar_stable", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                                 m_arcache, m_arprot, m_arqos}, held);
            if (m_arready) begin
               held_v = 1'b0;
               if (exp_ar.size() == 0) begin
                  chk("ar_spurious", 1'b1, 1'b0);
               end else begin
                  e = exp_ar.pop_front();
                  chk("ar_addr", m_araddr, e.addr);
                  chk("ar_len", m_arlen, e.len);
                  chk("ar_attr", {m_arid, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot,
                                  m_arqos}, exp_attr);
                  pend.push_back(int'(m_arlen) + 1);
                  b2b_flag = (exp_ar.size() > 0) ? 1 : 2;
               end
            end else begin
               held_v = 1'b1;
               held   = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                         m_arcache, m_arprot, m_arqos};
            end
         end
         if (m_rvalid) begin
            chk("s_rvalid", s_rvalid, 1'b1);
            chk("m_rready", m_rready, s_rready);
            if (m_rready) begin
               r_hs = 1'b1;
               chk("s_rdata", s_rdata, m_rdata);
               chk("s_rid_resp", {s_rid, s_rresp}, {m_rid, m_rresp});
               chk("s_rlast", s_rlast, (beat_idx + 1 == exp_total));
               beat_idx++;
               if (beat_idx == exp_total) begin
                  done = 1'b1;
                  busy = 1'b0;
               end
            end
         end
      end
      @(posedge clk_clk);
      #1;
      if (!reset_reset_n) begin
         pend.delete();
         cur_left  = 0;
         m_rvalid  = 1'b0;
         m_rlast   = 1'b0;
         m_arready = 1'b1;
         held_v    = 1'b0;
         b2b_flag  = 0;
      end else begin
         if (ar_stall > 0 && m_arvalid) begin
            m_arready = 1'b0;
            ar_stall--;
         end else begin
            m_arready = rand_ar ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         s_rready = rand_r ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (!m_rvalid || r_hs) begin
            if (cur_left == 0 && pend.size() > 0) cur_left = pend.pop_front();
            if (cur_left > 0 && (!rand_r || $urandom_range(0, 3) != 0)) begin
               m_rvalid = 1'b1;
               m_rdata  = {$urandom, $urandom};
               m_rresp  = 2'($urandom_range(0, 3));
               m_rid    = cur_id;
               cur_left--;
               m_rlast  = (cur_left == 0);
            end else begin
               m_rvalid = 1'b0;
               m_rlast  = 1'b0;
            end
         end
      end
   end

   // ---------------- master-side driver ----------------
   task automatic issue_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic       lock;
      logic [3:0] cache, qos;
      logic [2:0] prot;
      bit         acc;
      lock  = 1'($urandom);
      cache = 4'($urandom);
      prot  = 3'($urandom);
      qos   = 4'($urandom);
      model_split(addr, len, size, burst);
      exp_attr  = {id, size, burst, lock, cache, prot, qos};
      exp_total = int'(len) + 1;
      beat_idx  = 0;
      done      = 1'b0;
      cur_id    = id;
      @(posedge clk_clk);
      #1;
      s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
      s_arlock = lock; s_arcache = cache; s_arprot = prot; s_arqos = qos;
      s_arvalid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_clk);
         if (s_arready) begin
            acc = 1'b1;
            break;
         end
      end
      chk("ar_accept", acc, 1'b1);
      @(posedge clk_clk);
      #1;
      s_arvalid = 1'b0;
      if (acc) begin
         busy = 1'b1;
         @(negedge clk_clk);
         chk("ar_latency", m_arvalid, 1'b1);
      end else begin
         exp_ar.delete();
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 4000 && !done; i++) @(negedge clk_clk);
      chk("burst_done", done, 1'b1);
      chk("ar_all_issued", exp_ar.size(), 0);
      repeat (2) @(negedge clk_clk);
      chk("no_extra_r", pend.size() + cur_left, 0);
      if (!done) begin
         busy = 1'b0;
         exp_ar.delete();
      end
   endtask

   task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      issue_ar(id, addr, len, size, burst);
      wait_done();
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      int unsigned       sel, bytes;

      repeat (3) @(negedge clk_clk);
      chk("rst_m_arvalid", m_arvalid, 1'b0);
      chk("rst_s_arready", s_arready, 1'b0);
      chk("rst_m_araddr", m_araddr, '0);
      chk("rst_m_arlen", m_arlen, '0);
      chk("rst_s_rvalid", s_rvalid, 1'b0);
      #1 reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      chk("idle_s_arready", s_arready, 1'b1);

      run_burst(4'h1, 30'h1000, 8'd3,  3'd3, BURST_INCR);
      run_burst(4'h2, 30'h1000, 8'd63, 3'd3, BURST_INCR);
      run_burst(4'h3, 30'h1004, 8'd31, 3'd3, BURST_INCR);
      run_burst(4'h4, 30'h2010, 8'd7,  3'd3, BURST_WRAP);

      ar_stall = 5;
      rand_r   = 1'b1;
      run_burst(4'h5, 30'h3000, 8'd63, 3'd3, BURST_INCR);

      rand_ar = 1'b1;
      for (int t = 0; t < 8; t++) begin
         sel   = $urandom_range(0, 5);
         size  = 3'($urandom_range(0, 3));
         bytes = 1 << size;
         addr  = ADDR_W'($urandom);
         if (sel == 0) begin
            burst = BURST_FIXED;
            len   = 8'($urandom_range(0, 15));
            addr  = addr & ~ADDR_W'(bytes - 1);
         end else if (sel == 1) begin
            burst = BURST_WRAP;
            len   = 8'((2 << $urandom_range(0, 3)) - 1);
            addr  = addr & ~ADDR_W'(bytes - 1);
         end else begin
            burst = BURST_INCR;
            len   = 8'($urandom_range(0, 255));
            if ((int'(addr[11:0]) + (int'(len) + 1) * int'(bytes)) > 4096)
               addr = addr & ~ADDR_W'(12'hFFF);
         end
         run_burst(4'($urandom), addr, len, size, burst);
      end

      // reset while the last sub-burst's data is still draining
      rand_ar = 1'b0;
      issue_ar(4'h6, 30'h4000, 8'd63, 3'd3, BURST_INCR);
      for (int i = 0; i < 3000 && beat_idx < 50; i++) @(negedge clk_clk);
      chk("reach_drain", (beat_idx >= 50), 1'b1);
      #2 reset_reset_n = 1'b0;
      busy = 1'b0;
      exp_ar.delete();
      #1;
      chk("rst_mid_m_arvalid", m_arvalid, 1'b0);
      chk("rst_mid_s_arready", s_arready, 1'b0);
      repeat (2) @(negedge clk_clk);
      #1 reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      chk("post_rst_s_arready", s_arready, 1'b1);
      rand_r = 1'b0;
      run_burst(4'h7, 30'h5000, 8'd0, 3'd3, BURST_INCR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ddr3_axi4_rd_splitter
